// File: rtl/mux_n_pipe.sv
// ============================================================================
// mux_n_pipe
// ----------------------------------------------------------------------------
// Parametrised NUM_IN-input, WIDTH-bit operand-select multiplexer with a
// registered output stage and a valid/ready handshake on both sides.
//
// It replaces the fixed 3:1 combinational operand mux that sat between the
// register-file/forwarding sources and the ALU operand latch. A two-entry
// skid buffer (main + skid register) gives full throughput under
// backpressure while keeping in_ready a pure register output.
//
// Parameters:
//   WIDTH   data width of every input and of the output
//   NUM_IN  number of selectable inputs (2..16)
//   SEL_W   select width, 2**SEL_W must be >= NUM_IN
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    packed inputs, input k at bits [k*WIDTH +: WIDTH]
//   sel        input index, sampled together with in_valid
//   in_valid   source presents a valid sel/in_data this cycle
//   in_ready   block can accept this cycle (registered, = !skid valid)
//   flush      synchronous discard of all buffered entries
//   out_data   selected data (holds its last value while invalid)
//   out_valid  out_data is valid
//   out_ready  sink accepts out_data this cycle
//   sel_err    sticky out-of-range select flag (optional, see below)
//
// Optional feature:
//   Define MUX_N_PIPE_SEL_ERR_EN to add the sel_err port. It is set the
//   cycle after any accepted transfer whose sel >= NUM_IN and is cleared
//   only by reset. Without the macro the port and its logic do not exist
//   and out-of-range selects silently yield zero data.
// ============================================================================
module mux_n_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef MUX_N_PIPE_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);

    // Buffer occupancy, encoded as {skid_valid, main_valid}. The skid
    // register is only ever filled while main is valid, so 2'b10 cannot
    // occur in normal operation.
    localparam logic [1:0] OCC_EMPTY = 2'b00;
    localparam logic [1:0] OCC_ONE   = 2'b01;
    localparam logic [1:0] OCC_FULL  = 2'b11;

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] main_data;
    logic             main_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic [1:0]       occ;
    logic             accept;
    logic             emit;

    // ------------------------------------------------------------------
    // Input-side select
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: the default assignment ahead of the loop covers every path,
        // so no latch is inferred and an out-of-range sel falls through to
        // all-zero data instead of holding a previous value.
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // in_ready comes straight from a flop, so there is no combinational
    // path from out_ready back to the source.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign emit     = out_valid && out_ready;
    assign occ      = {skid_valid, main_valid};

    assign out_valid = main_valid;
    assign out_data  = main_data;

    // ------------------------------------------------------------------
    // Main + skid storage
    // ------------------------------------------------------------------
    // Data registers are loaded only on a transfer, so an invalid stage
    // keeps its last value and out_data does not toggle while idle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register in this block sees the pre-edge values of the others.
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            // Flush wins over a same-cycle accept. A same-cycle emit has
            // already been seen by the sink, so dropping main is correct.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (accept) begin
                        main_data  <= sel_data;
                        main_valid <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (accept && emit) begin
                        main_data <= sel_data;
                    end else if (accept) begin
                        skid_data  <= sel_data;
                        skid_valid <= 1'b1;
                    end else if (emit) begin
                        main_valid <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only the drain side moves.
                    if (emit) begin
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to empty.
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_N_PIPE_SEL_ERR_EN
    // ------------------------------------------------------------------
    // Sticky out-of-range select flag
    // ------------------------------------------------------------------
    logic sel_oor;

    assign sel_oor = (int'(sel) >= NUM_IN);

    // Any handshaken transfer counts, even one discarded by flush; the
    // source did present a bad select. Only reset clears the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else if (accept && sel_oor) begin
            sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// ============================================================================
// tb_mux_n_pipe
// ----------------------------------------------------------------------------
// Self-checking bench for mux_n_pipe (WIDTH=32, NUM_IN=3, SEL_W=2).
// Inputs change shortly after each rising edge; handshakes are evaluated on
// the falling edge. Every accepted item pushes its expected value (computed
// from the bench's own copy of the inputs) into a queue; every emitted item
// pops and compares. Directed tasks add inline checks for reset values,
// latency, in_ready behaviour, flush, async reset and output stability.
// ============================================================================
module tb_mux_n_pipe;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
`ifdef MUX_N_PIPE_SEL_ERR_EN
    logic                    sel_err;
`endif

    logic [WIDTH-1:0] inputs [NUM_IN];
    logic [WIDTH-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    assign in_data = {inputs[2], inputs[1], inputs[0]};

    always #5 clk = ~clk;

    mux_n_pipe #(
        .WIDTH (WIDTH),
        .NUM_IN(NUM_IN),
        .SEL_W (SEL_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .sel      (sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef MUX_N_PIPE_SEL_ERR_EN
        ,
        .sel_err  (sel_err)
`endif
    );

    // Reference select: in-range picks the input, out-of-range is zero.
    function automatic logic [WIDTH-1:0] model_sel(input logic [SEL_W-1:0] s);
        if (int'(s) < NUM_IN) return inputs[s];
        return '0;
    endfunction

    // One clock cycle: evaluate handshakes on the falling edge, update the
    // scoreboard, then return 1 ns after the next rising edge.
    task automatic step(output bit acc);
        bit emit;
        logic [WIDTH-1:0] exp;
        @(negedge clk);
        acc  = (in_valid === 1'b1) && (in_ready === 1'b1);
        emit = (out_valid === 1'b1) && (out_ready === 1'b1);
        if (emit) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL emit_unexpected: got out_data=%h, required no output", out_data);
            end else begin
                exp = exp_q.pop_front();
                if (out_data !== exp) begin
                    bad++;
                    $display("FAIL emit_data: got %h, required %h", out_data, exp);
                end
            end
        end
        if (flush === 1'b1) exp_q.delete();
        else if (acc) exp_q.push_back(model_sel(sel));
        @(posedge clk);
        #1;
    endtask

    task automatic step1();
        bit a;
        step(a);
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 20) begin
            step1();
            n++;
        end
        total++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain: got %0d items left, out_valid=%b, required 0 and 0",
                     exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        total++;
        if (out_data !== '0) begin
            bad++; $display("FAIL reset_out_data: got %h, required 0", out_data);
        end
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
`ifdef MUX_N_PIPE_SEL_ERR_EN
        total++;
        if (sel_err !== 1'b0) begin
            bad++; $display("FAIL reset_sel_err: got %b, required 0", sel_err);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_select();
        logic [WIDTH-1:0] want [NUM_IN];
        want[0] = 32'h1111_1111;
        want[1] = 32'h2222_2222;
        want[2] = 32'h3333_3333;
        for (int s = 1; s < 1 + NUM_IN; s++) begin
            in_valid  = 1'b1;
            sel       = SEL_W'(s % NUM_IN);
            out_ready = 1'b1;
            step1();
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1 || out_data !== want[s % NUM_IN]) begin
                bad++;
                $display("FAIL select_%0d: got valid=%b data=%h, required 1 %h",
                         s % NUM_IN, out_valid, out_data, want[s % NUM_IN]);
            end
            step1();
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL select_idle: got out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_out_of_range();
        in_valid  = 1'b1;
        sel       = 2'd3;
        out_ready = 1'b1;
        step1();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h0) begin
            bad++;
            $display("FAIL oor_data: got valid=%b data=%h, required 1 00000000", out_valid, out_data);
        end
`ifdef MUX_N_PIPE_SEL_ERR_EN
        total++;
        if (sel_err !== 1'b1) begin
            bad++; $display("FAIL oor_sel_err: got %b, required 1", sel_err);
        end
`endif
        step1();
        flush = 1'b1;
        step1();
        flush = 1'b0;
        step1();
`ifdef MUX_N_PIPE_SEL_ERR_EN
        total++;
        if (sel_err !== 1'b1) begin
            bad++; $display("FAIL oor_sel_err_after_flush: got %b, required 1", sel_err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [SEL_W-1:0] seq [4];
        int idx = 0;
        int cyc = 0;
        int accepts = 0;
        bit acc;
        seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd0;
        // Backpressure: sink stalls for the first two cycles.
        while ((idx < 4 || exp_q.size() != 0) && cyc < 40) begin
            out_ready = (cyc >= 2);
            in_valid  = (idx < 4);
            sel       = (idx < 4) ? seq[idx] : 2'd0;
            step(acc);
            if (acc) idx++;
            cyc++;
            if (cyc == 2) begin
                total++;
                if (in_ready !== 1'b0) begin
                    bad++; $display("FAIL bp_in_ready_low: got %b, required 0", in_ready);
                end
            end
        end
        in_valid = 1'b0;
        total++;
        if (idx != 4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_complete: got %0d accepted %0d pending, required 4 and 0", idx, exp_q.size());
        end
        // Throughput: with the sink always ready, one accept per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            sel      = SEL_W'(i % NUM_IN);
            step(acc);
            if (acc) accepts++;
        end
        total++;
        if (accepts != 8) begin
            bad++; $display("FAIL throughput: got %0d accepts in 8 cycles, required 8", accepts);
        end
        drain();
    endtask

    task automatic test_flush();
        // Flush from FULL with a pending input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 2'd0; step1();
        sel = 2'd1; step1();
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL flush_full_state: got in_ready=%b, required 0", in_ready);
        end
        sel = 2'd2; flush = 1'b1; step1();
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_full: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (3) step1();
        // Flush in ONE with an accept that in_ready would otherwise allow.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 2'd0; step1();
        sel = 2'd2; flush = 1'b1; step1();
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_accept_drop: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        repeat (3) step1();
        // Flush together with an emit: the emit is still a real handshake.
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1; step1();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; step1();
        flush = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_with_emit: got out_valid=%b, required 0", out_valid);
        end
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd1;
        step1();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL async_reset: got valid=%b data=%h, required 0 00000000", out_valid, out_data);
        end
        exp_q.delete();
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: got ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
`ifdef MUX_N_PIPE_SEL_ERR_EN
        total++;
        if (sel_err !== 1'b0) begin
            bad++; $display("FAIL post_reset_sel_err: got %b, required 0", sel_err);
        end
`endif
        in_valid  = 1'b1;
        sel       = 2'd2;
        out_ready = 1'b1;
        step1();
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 32'h3333_3333) begin
            bad++;
            $display("FAIL post_reset_latency: got valid=%b data=%h, required 1 33333333", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_stability();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel       = 2'd2;
        step1();
        for (int i = 0; i < 5; i++) begin
            inputs[0] = $urandom;
            inputs[1] = $urandom;
            inputs[2] = $urandom;
            sel       = SEL_W'(i % NUM_IN);
            step1();
            total++;
            if (out_valid !== 1'b1 || out_data !== 32'h3333_3333) begin
                bad++;
                $display("FAIL stable_%0d: got valid=%b data=%h, required 1 33333333", i, out_valid, out_data);
            end
        end
        drain();
        inputs[0] = 32'h1111_1111;
        inputs[1] = 32'h2222_2222;
        inputs[2] = 32'h3333_3333;
    endtask

    initial begin
        inputs[0] = 32'h1111_1111;
        inputs[1] = 32'h2222_2222;
        inputs[2] = 32'h3333_3333;
        in_valid  = 1'b0;
        sel       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_select();
        test_out_of_range();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_stability();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
